ym3438_host_wr: RTL

Host-side bus initiator that drives the YM3438 CPU port: it accepts register-write requests (bank, register address, data) from a sequencer or soft CPU, queues them, and converts each into the chip's two-phase address-write / data-write cycle on CS/WR/RD/A1/A0/D. It also generates the power-on IC pulse and paces writes against the chip's busy flag, so the chip's own write-enable and busy logic never sees an overrun. It sits between the system register-write source and the ym3438 top-level bus pins.

---
 rtl/ym3438_host_wr.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ym3438_host_wr.sv
// ym3438_host_wr: queued register-write initiator for the YM3438 CPU port (IC pulse, two-phase writes, busy pacing).
// Define YM3438_HOST_BUSY_POLL_EN to pace writes by polling the status busy bit instead of a fixed wait.
module ym3438_host_wr #(
    parameter int DEPTH            = 4,
    parameter int STROBE_CYCLES    = 4,
    parameter int GAP_CYCLES       = 12,
    parameter int IC_CYCLES        = 192,
    parameter int BUSY_WAIT_CYCLES = 192,
    parameter int BUSY_TIMEOUT     = 64
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_bank,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       ic_n,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [1:0] bus_addr,
    output logic [7:0] bus_data,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       idle,
    output logic       err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int NW   = AW + 1;
    localparam int M1   = (IC_CYCLES > BUSY_WAIT_CYCLES) ? IC_CYCLES : BUSY_WAIT_CYCLES;
    localparam int M2   = (GAP_CYCLES > STROBE_CYCLES) ? GAP_CYCLES : STROBE_CYCLES;
    localparam int CW   = $clog2(((M1 > M2) ? M1 : M2) + 1);

    typedef enum logic [3:0] {
        S_INIT         = 4'd0,
        S_IDLE         = 4'd1,
        S_A_SETUP      = 4'd2,
        S_A_STROBE     = 4'd3,
        S_A_HOLD       = 4'd4,
        S_GAP          = 4'd5,
        S_D_SETUP      = 4'd6,
        S_D_STROBE     = 4'd7,
        S_D_HOLD       = 4'd8,
        S_POST         = 4'd9,
        S_POLL_STROBE  = 4'd10,
        S_POLL_RELEASE = 4'd11
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [16:0]     mem_r [DEPTH];
    logic [AW-1:0]   wptr_r, rptr_r;
    logic [NW-1:0]   count_r, count_s;
    logic            push_s, pop_s, err_set_s;
    logic [16:0]     head_s, hold_r, cur_s;
    logic            ic_n_s, cs_n_s, wr_n_s, rd_n_s, oe_s, ready_s, idle_s;
    logic [1:0]      addr_s;
    logic [7:0]      data_s;

`ifdef YM3438_HOST_BUSY_POLL_EN
    localparam int PW = $clog2(BUSY_TIMEOUT + 1);
    logic            busy_r;
    logic [PW-1:0]   polls_r;
`else
    localparam int unused_timeout = BUSY_TIMEOUT;
    logic            unused_din_s;
    assign unused_din_s = ^bus_din;
`endif

    assign push_s = req_valid & req_ready;
    assign head_s = mem_r[rptr_r];
    assign cur_s  = pop_s ? head_s : hold_r;

    // Next-state, pop decision and phase counter
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            S_INIT:     if (cnt_r == CW'(IC_CYCLES - 1)) state_s = S_IDLE; else state_s = S_INIT;
            S_IDLE: begin
                if (count_r != {NW{1'b0}}) begin
                    pop_s   = 1'b1;
                    state_s = S_A_SETUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_A_SETUP:  state_s = S_A_STROBE;
            S_A_STROBE: if (cnt_r == CW'(STROBE_CYCLES - 1)) state_s = S_A_HOLD; else state_s = S_A_STROBE;
            S_A_HOLD:   if (GAP_CYCLES == 0) state_s = S_D_SETUP; else state_s = S_GAP;
            S_GAP:      if (cnt_r == CW'(GAP_CYCLES - 1)) state_s = S_D_SETUP; else state_s = S_GAP;
            S_D_SETUP:  state_s = S_D_STROBE;
            S_D_STROBE: if (cnt_r == CW'(STROBE_CYCLES - 1)) state_s = S_D_HOLD; else state_s = S_D_STROBE;
`ifdef YM3438_HOST_BUSY_POLL_EN
            S_D_HOLD:   state_s = S_POLL_STROBE;
            S_POLL_STROBE: if (cnt_r == CW'(STROBE_CYCLES - 1)) state_s = S_POLL_RELEASE; else state_s = S_POLL_STROBE;
            S_POLL_RELEASE: begin
                if (!busy_r) begin
                    state_s = S_IDLE;
                end else if (polls_r == PW'(BUSY_TIMEOUT)) begin
                    state_s   = S_IDLE;
                    err_set_s = 1'b1;
                end else begin
                    state_s = S_POLL_STROBE;
                end
            end
`else
            S_D_HOLD:   state_s = S_POST;
            S_POST:     if (cnt_r == CW'(BUSY_WAIT_CYCLES - 1)) state_s = S_IDLE; else state_s = S_POST;
`endif
            default:    state_s = S_INIT;
        endcase
        if (state_s != state_r) cnt_s = {CW{1'b0}};
        else                    cnt_s = cnt_r + CW'(1);
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        if (push_s && !pop_s)      count_s = count_r + NW'(1);
        else if (!push_s && pop_s) count_s = count_r - NW'(1);
        else                       count_s = count_r;
        ready_s = (state_s != S_INIT) && (count_s != NW'(DEPTH));
        idle_s  = (state_s == S_IDLE) && (count_s == {NW{1'b0}});
    end

    // Pin values for the state being entered, so every pin leaves a flop
    always_comb begin
        ic_n_s = 1'b1;
        cs_n_s = 1'b1;
        wr_n_s = 1'b1;
        rd_n_s = 1'b1;
        oe_s   = 1'b0;
        addr_s = bus_addr;
        data_s = bus_data;
        case (state_s)
            S_INIT: ic_n_s = 1'b0;
            S_A_SETUP, S_A_HOLD, S_A_STROBE: begin
                oe_s   = 1'b1;
                addr_s = {cur_s[16], 1'b0};
                data_s = cur_s[15:8];
                if (state_s == S_A_STROBE) begin cs_n_s = 1'b0; wr_n_s = 1'b0; end
                else                       begin cs_n_s = 1'b1; wr_n_s = 1'b1; end
            end
            S_D_SETUP, S_D_HOLD, S_D_STROBE: begin
                oe_s   = 1'b1;
                addr_s = {cur_s[16], 1'b1};
                data_s = cur_s[7:0];
                if (state_s == S_D_STROBE) begin cs_n_s = 1'b0; wr_n_s = 1'b0; end
                else                       begin cs_n_s = 1'b1; wr_n_s = 1'b1; end
            end
`ifdef YM3438_HOST_BUSY_POLL_EN
            S_POLL_STROBE: begin
                cs_n_s = 1'b0;
                rd_n_s = 1'b0;
                addr_s = 2'b00;
            end
`endif
            default: oe_s = 1'b0;
        endcase
    end

    // Control state, FIFO pointers, holding register and registered pins
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_r   <= S_INIT;
            cnt_r     <= {CW{1'b0}};
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            count_r   <= {NW{1'b0}};
            hold_r    <= 17'd0;
            ic_n      <= 1'b0;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            bus_addr  <= 2'b00;
            bus_data  <= 8'h00;
            bus_oe    <= 1'b0;
            req_ready <= 1'b0;
            idle      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            wptr_r    <= push_s ? wptr_r + AW'(1) : wptr_r;
            rptr_r    <= pop_s ? rptr_r + AW'(1) : rptr_r;
            count_r   <= count_s;
            hold_r    <= cur_s;
            ic_n      <= ic_n_s;
            cs_n      <= cs_n_s;
            wr_n      <= wr_n_s;
            rd_n      <= rd_n_s;
            bus_addr  <= addr_s;
            bus_data  <= data_s;
            bus_oe    <= oe_s;
            req_ready <= ready_s;
            idle      <= idle_s;
            err       <= err | err_set_s;
        end
    end

    // FIFO storage; contents are don't-care until a push marks them valid
    always_ff @(posedge MCLK) begin
        if (push_s) mem_r[wptr_r] <= {req_bank, req_addr, req_data};
    end

`ifdef YM3438_HOST_BUSY_POLL_EN
    // Busy sample on the final read-strobe cycle and poll count per write
    always_ff @(posedge MCLK) begin
        if (reset) begin
            busy_r  <= 1'b0;
            polls_r <= {PW{1'b0}};
        end else if (state_r == S_D_HOLD) begin
            busy_r  <= 1'b0;
            polls_r <= {PW{1'b0}};
        end else if (state_r == S_POLL_STROBE && cnt_r == CW'(STROBE_CYCLES - 1)) begin
            busy_r  <= bus_din[7];
            polls_r <= polls_r + PW'(1);
        end
    end
`endif

endmodule
